// File: rtl/oc_bank_read_arbiter_if.sv
// Bus bundle between the register-allocation unit / write-back path and the
// operand-collector bank read arbiter, plus the per-bank tag return lanes.
interface oc_bank_read_arbiter_if #(
    parameter int unsigned NUM_OC = 4,
    parameter int unsigned ROW_W  = 3
);
    localparam int unsigned NUM_SLOT = 2 * NUM_OC;
    localparam int unsigned SLOT_W   = $clog2(NUM_SLOT);

    // request side
    logic [NUM_SLOT-1:0]       alloc_vld;
    logic [2*NUM_SLOT-1:0]     alloc_bank;
    logic [ROW_W*NUM_SLOT-1:0] alloc_row;
    // 'release' is a reserved word, so the per-OC dispatch pulse is oc_release
    logic [NUM_OC-1:0]         oc_release;
    logic                      wb_vld;
    logic [1:0]                wb_bank;

    // bank read side
    logic [3:0]                bank_rd_en;
    logic [4*ROW_W-1:0]        bank_rd_row;

    // tag return lanes, aligned with bank read data
    logic [SLOT_W-1:0]         bk_0_ocid;
    logic [SLOT_W-1:0]         bk_1_ocid;
    logic [SLOT_W-1:0]         bk_2_ocid;
    logic [SLOT_W-1:0]         bk_3_ocid;
    logic                      bk_0_vld;
    logic                      bk_1_vld;
    logic                      bk_2_vld;
    logic                      bk_3_vld;
    logic                      bk_0_bz;
    logic                      bk_1_bz;
    logic                      bk_2_bz;
    logic                      bk_3_bz;

    logic [NUM_SLOT-1:0]       pending;

    modport master (
        output alloc_vld, alloc_bank, alloc_row, oc_release, wb_vld, wb_bank,
        input  bank_rd_en, bank_rd_row,
        input  bk_0_ocid, bk_1_ocid, bk_2_ocid, bk_3_ocid,
        input  bk_0_vld, bk_1_vld, bk_2_vld, bk_3_vld,
        input  bk_0_bz, bk_1_bz, bk_2_bz, bk_3_bz,
        input  pending
    );

    modport slave (
        input  alloc_vld, alloc_bank, alloc_row, oc_release, wb_vld, wb_bank,
        output bank_rd_en, bank_rd_row,
        output bk_0_ocid, bk_1_ocid, bk_2_ocid, bk_3_ocid,
        output bk_0_vld, bk_1_vld, bk_2_vld, bk_3_vld,
        output bk_0_bz, bk_1_bz, bk_2_bz, bk_3_bz,
        output pending
    );
endinterface

// File: rtl/oc_bank_read_arbiter.sv
// Operand-collector register-bank read arbiter.
// Holds one pending read per collector slot (slot = 2*oc + operand), picks at
// most one slot per bank each cycle with a per-bank round-robin pointer, issues
// the bank read and returns the slot tag aligned with the bank read data.
// Write-back owns a bank in the cycle it is announced; that bank reports bz.
// NUM_OC and ROW_W must match the parameters of the connected interface.
module oc_bank_read_arbiter #(
    parameter int unsigned NUM_OC = 4,
    parameter int unsigned ROW_W  = 3
) (
    input logic                   clk,
    input logic                   rst,
    oc_bank_read_arbiter_if.slave bus
);
    localparam int unsigned NUM_SLOT = 2 * NUM_OC;
    localparam int unsigned SLOT_W   = $clog2(NUM_SLOT);
    localparam int unsigned NUM_BANK = 4;

    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [1:0]        bank_t;
    typedef logic [ROW_W-1:0]  row_t;

    // request store
    logic [NUM_SLOT-1:0] pend_q;
    bank_t               req_bank_q [NUM_SLOT];
    row_t                req_row_q  [NUM_SLOT];
    slot_t               rr_ptr_q   [NUM_BANK];

    // arbitration results for the current cycle
    logic [NUM_BANK-1:0] blocked;
    logic [NUM_BANK-1:0] gnt_vld;
    slot_t               gnt_slot [NUM_BANK];
    row_t                gnt_row  [NUM_BANK];
    logic [NUM_SLOT-1:0] gnt_mask;
    logic [NUM_SLOT-1:0] kill_mask;

    // issue stage and tag pipeline
    logic [NUM_BANK-1:0] rd_en_q;
    row_t                rd_row_q  [NUM_BANK];
    logic [NUM_BANK-1:0] s1_vld_q;
    logic [NUM_BANK-1:0] s1_bz_q;
    slot_t               s1_slot_q [NUM_BANK];
    logic [NUM_BANK-1:0] out_vld_q;
    logic [NUM_BANK-1:0] out_bz_q;
    slot_t               out_ocid_q [NUM_BANK];

    // Expand the per-OC release pulse to both of its operand slots.
    always_comb begin
        kill_mask = '0;
        for (int unsigned s = 0; s < NUM_SLOT; s++) begin
            kill_mask[s] = bus.oc_release[s/2];
        end
    end

    // Per-bank round-robin pick among pending slots targeting that bank.
    always_comb begin : arb
        slot_t idx;
        idx      = '0;
        blocked  = '0;
        gnt_vld  = '0;
        gnt_mask = '0;
        for (int unsigned b = 0; b < NUM_BANK; b++) begin
            gnt_slot[b] = '0;
            gnt_row[b]  = '0;
        end
        for (int unsigned b = 0; b < NUM_BANK; b++) begin
            blocked[b] = bus.wb_vld && (bus.wb_bank == bank_t'(b));
            // scan from the pointer upwards, wrapping past the last slot
            for (int unsigned off = 0; off < NUM_SLOT; off++) begin
                idx = slot_t'((32'(rr_ptr_q[b]) + off) % NUM_SLOT);
                if (!blocked[b] && !gnt_vld[b] && pend_q[idx] &&
                    (req_bank_q[idx] == bank_t'(b))) begin
                    gnt_vld[b]  = 1'b1;
                    gnt_slot[b] = idx;
                    gnt_row[b]  = req_row_q[idx];
                end
            end
            if (gnt_vld[b]) begin
                gnt_mask[gnt_slot[b]] = 1'b1;
            end
        end
    end

    // Request latch: alloc beats release, release beats grant-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            for (int unsigned s = 0; s < NUM_SLOT; s++) begin
                req_bank_q[s] <= '0;
                req_row_q[s]  <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < NUM_SLOT; s++) begin
                if (bus.alloc_vld[s]) begin
                    pend_q[s]     <= 1'b1;
                    req_bank_q[s] <= bus.alloc_bank[2*s +: 2];
                    req_row_q[s]  <= bus.alloc_row[ROW_W*s +: ROW_W];
                end else if (kill_mask[s] || gnt_mask[s]) begin
                    pend_q[s] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointers advance past the slot just granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned b = 0; b < NUM_BANK; b++) begin
                rr_ptr_q[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < NUM_BANK; b++) begin
                if (gnt_vld[b]) begin
                    rr_ptr_q[b] <= (32'(gnt_slot[b]) == NUM_SLOT - 1) ? '0
                                 : gnt_slot[b] + slot_t'(1);
                end
            end
        end
    end

    // Grant edge: register the bank read and the first tag stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q  <= '0;
            s1_vld_q <= '0;
            s1_bz_q  <= '0;
            for (int unsigned b = 0; b < NUM_BANK; b++) begin
                rd_row_q[b]  <= '0;
                s1_slot_q[b] <= '0;
            end
        end else begin
            rd_en_q <= gnt_vld;
            for (int unsigned b = 0; b < NUM_BANK; b++) begin
                rd_row_q[b]  <= gnt_vld[b] ? gnt_row[b] : '0;
                // a release in the grant cycle already kills the tag
                s1_vld_q[b]  <= gnt_vld[b] && !kill_mask[gnt_slot[b]];
                s1_slot_q[b] <= gnt_slot[b];
                s1_bz_q[b]   <= blocked[b];
            end
        end
    end

    // Return edge: tag lines up with the one-cycle synchronous bank read.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= '0;
            out_bz_q  <= '0;
            for (int unsigned b = 0; b < NUM_BANK; b++) begin
                out_ocid_q[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < NUM_BANK; b++) begin
                out_vld_q[b]  <= s1_vld_q[b] && !kill_mask[s1_slot_q[b]];
                out_ocid_q[b] <= s1_slot_q[b];
                out_bz_q[b]   <= s1_bz_q[b];
            end
        end
    end

    // Flatten the per-bank row registers onto the bank row bus.
    always_comb begin
        bus.bank_rd_row = '0;
        for (int unsigned b = 0; b < NUM_BANK; b++) begin
            bus.bank_rd_row[ROW_W*b +: ROW_W] = rd_row_q[b];
        end
    end

    assign bus.bank_rd_en = rd_en_q;
    assign bus.pending    = pend_q;

    assign bus.bk_0_ocid  = out_ocid_q[0];
    assign bus.bk_1_ocid  = out_ocid_q[1];
    assign bus.bk_2_ocid  = out_ocid_q[2];
    assign bus.bk_3_ocid  = out_ocid_q[3];
    assign bus.bk_0_vld   = out_vld_q[0];
    assign bus.bk_1_vld   = out_vld_q[1];
    assign bus.bk_2_vld   = out_vld_q[2];
    assign bus.bk_3_vld   = out_vld_q[3];
    assign bus.bk_0_bz    = out_bz_q[0];
    assign bus.bk_1_bz    = out_bz_q[1];
    assign bus.bk_2_bz    = out_bz_q[2];
    assign bus.bk_3_bz    = out_bz_q[3];
endmodule
